// File: rtl/legv8_multicycle_ctrl.sv
// Multi-cycle LEGv8 control sequencer: steps one opcode through DECODE/EXEC/MEM/WB,
// drives datapath selects/enables and counts retired instructions.
module legv8_multicycle_ctrl #(
   parameter int RET_W = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             instr_valid,
   input  logic [10:0]      opcode,
   output logic             instr_ready,
   input  logic             alu_zero,
   input  logic             mem_ready,
   output logic             alu_src,
   output logic             reg2loc,
   output logic [1:0]       alu_op,
   output logic             mem_read,
   output logic             mem_write,
   output logic             mem_to_reg,
   output logic             reg_write,
   output logic             pc_write,
   output logic             pc_src,
   output logic             illegal,
   input  logic             trap_clr,
   output logic [RET_W-1:0] retired
);

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_DECODE = 3'd2,
      S_EXEC   = 3'd3,
      S_MEM    = 3'd4,
      S_WB     = 3'd5,
      S_TRAP   = 3'd6
   } state_t;

   typedef enum logic [2:0] {
      C_R, C_LDUR, C_STUR, C_CBZ, C_B, C_ILL
   } cls_t;

   state_t state, state_next;
   cls_t   cls, dec_cls;

   always_comb begin
      dec_cls = C_ILL;
      if (opcode == 11'b10001011000 || opcode == 11'b11001011000 ||
          opcode == 11'b10001010000 || opcode == 11'b10101010000)
         dec_cls = C_R;
      else if (opcode == 11'b11111000010)
         dec_cls = C_LDUR;
      else if (opcode == 11'b11111000000)
         dec_cls = C_STUR;
      else if (opcode[10:3] == 8'b10110100)
         dec_cls = C_CBZ;
      else if (opcode[10:5] == 6'b000101)
         dec_cls = C_B;
   end

   // The opcode is only looked at on the accept edge; afterwards everything keys off cls.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= S_IDLE;
         cls     <= C_ILL;
         retired <= '0;
      end else begin
         state <= state_next;
         if (state == S_IDLE && instr_valid)
            cls <= dec_cls;
         if (pc_write)
            retired <= retired + RET_W'(1);
      end
   end

   always_comb begin
      state_next  = state;
      instr_ready = 1'b0;
      alu_src     = 1'b0;
      alu_op      = 2'b00;
      mem_read    = 1'b0;
      mem_write   = 1'b0;
      mem_to_reg  = 1'b0;
      reg_write   = 1'b0;
      pc_write    = 1'b0;
      pc_src      = 1'b0;
      illegal     = 1'b0;
      reg2loc     = 1'b0;
      case (state)
         S_IDLE: begin
            instr_ready = 1'b1;
            if (instr_valid)
               state_next = S_DECODE;
         end
         S_DECODE: begin
            state_next = (cls == C_ILL) ? S_TRAP : S_EXEC;
         end
         S_EXEC: begin
            case (cls)
               C_R: begin
                  alu_op     = 2'b10;
                  state_next = S_WB;
               end
               C_LDUR, C_STUR: begin
                  alu_src    = 1'b1;
                  state_next = S_MEM;
               end
               C_CBZ: begin
                  alu_op     = 2'b01;
                  pc_write   = 1'b1;
                  pc_src     = alu_zero;
                  state_next = S_IDLE;
               end
               C_B: begin
                  pc_write   = 1'b1;
                  pc_src     = 1'b1;
                  state_next = S_IDLE;
               end
               default: state_next = S_IDLE;
            endcase
         end
         S_MEM: begin
            alu_src   = 1'b1;
            mem_read  = (cls == C_LDUR);
            mem_write = (cls == C_STUR);
            if (mem_ready) begin
               if (cls == C_LDUR) begin
                  state_next = S_WB;
               end else begin
                  pc_write   = (cls == C_STUR);
                  state_next = S_IDLE;
               end
            end
         end
         S_WB: begin
            reg_write  = 1'b1;
            pc_write   = 1'b1;
            mem_to_reg = (cls == C_LDUR);
            state_next = S_IDLE;
         end
         S_TRAP: begin
            illegal = 1'b1;
            if (trap_clr)
               state_next = S_IDLE;
         end
         default: state_next = S_IDLE;
      endcase
      // Rt stays selected for stores and CBZ for the whole time the instruction is in flight.
      if ((state == S_DECODE || state == S_EXEC || state == S_MEM || state == S_WB) &&
          (cls == C_STUR || cls == C_CBZ))
         reg2loc = 1'b1;
   end

endmodule

// File: tb/tb_legv8_multicycle_ctrl.sv
// Self-checking bench for legv8_multicycle_ctrl: table of single-instruction vectors
// plus hand-written reset, trap and counter-wrap sequences.
module tb_legv8_multicycle_ctrl;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        instr_valid;
   logic [10:0] opcode;
   logic        alu_zero;
   logic        mem_ready;
   logic        trap_clr;

   logic        instr_ready, alu_src, reg2loc, mem_read, mem_write, mem_to_reg;
   logic        reg_write, pc_write, pc_src, illegal;
   logic [1:0]  alu_op;
   logic [15:0] retired;

   logic        r4InstrReady, r4AluSrc, r4Reg2loc, r4MemRead, r4MemWrite, r4MemToReg;
   logic        r4RegWrite, r4PcWrite, r4PcSrc, r4Illegal;
   logic [1:0]  r4AluOp;
   logic [3:0]  r4Retired;

   int passCnt  = 0;
   int checkCnt = 0;
   int retModel = 0;

   always #5 clk = ~clk;

   legv8_multicycle_ctrl #(.RET_W(16)) dut (
      .clk(clk), .rst_n(rst_n), .instr_valid(instr_valid), .opcode(opcode),
      .instr_ready(instr_ready), .alu_zero(alu_zero), .mem_ready(mem_ready),
      .alu_src(alu_src), .reg2loc(reg2loc), .alu_op(alu_op), .mem_read(mem_read),
      .mem_write(mem_write), .mem_to_reg(mem_to_reg), .reg_write(reg_write),
      .pc_write(pc_write), .pc_src(pc_src), .illegal(illegal), .trap_clr(trap_clr),
      .retired(retired)
   );

   // Narrow-counter instance sees the same stimulus; used for the wrap check.
   legv8_multicycle_ctrl #(.RET_W(4)) dut4 (
      .clk(clk), .rst_n(rst_n), .instr_valid(instr_valid), .opcode(opcode),
      .instr_ready(r4InstrReady), .alu_zero(alu_zero), .mem_ready(mem_ready),
      .alu_src(r4AluSrc), .reg2loc(r4Reg2loc), .alu_op(r4AluOp), .mem_read(r4MemRead),
      .mem_write(r4MemWrite), .mem_to_reg(r4MemToReg), .reg_write(r4RegWrite),
      .pc_write(r4PcWrite), .pc_src(r4PcSrc), .illegal(r4Illegal), .trap_clr(trap_clr),
      .retired(r4Retired)
   );

   typedef struct {
      logic [10:0] opcode;
      bit          aluZero;
      int          nWait;
      int          expCycles;
      bit          expAluSrc;
      bit [1:0]    expAluOp;
      bit          expReg2loc;
      bit          expPcSrc;
      int          expRd;
      int          expWr;
      int          expRw;
      bit          expM2r;
   } vec_t;

   vec_t vecs[11];

   task automatic checkOutput(input string name, input int act, input int exp);
      checkCnt++;
      if (act == exp)
         passCnt++;
      else
         $display("[TB] FAIL %s: got %0d expected %0d", name, act, exp);
   endtask

   // Runs one legal instruction from IDLE (called at a negedge with instr_ready high).
   task automatic applyStimulus(input int idx, input vec_t v);
      int cyc, memCnt, rdCnt, wrCnt, rwCnt, pwCnt, ovl;
      bit obsAluSrc, obsReg2loc, obsPcSrc, obsM2r;
      bit [1:0] obsAluOp;
      cyc = 0; memCnt = 0; rdCnt = 0; wrCnt = 0; rwCnt = 0; pwCnt = 0; ovl = 0;
      obsAluSrc = 0; obsReg2loc = 0; obsPcSrc = 0; obsM2r = 0; obsAluOp = 0;
      opcode      = v.opcode;
      alu_zero    = v.aluZero;
      mem_ready   = 1'b0;
      instr_valid = 1'b1;
      @(posedge clk);
      #1 instr_valid = 1'b0;
      while (cyc < 40) begin
         @(negedge clk);
         cyc++;
         if (instr_ready) break;
         if (cyc == 1) obsReg2loc = reg2loc;
         if (cyc == 2) begin
            obsAluSrc = alu_src;
            obsAluOp  = alu_op;
         end
         if (mem_read || mem_write) begin
            mem_ready = (memCnt >= v.nWait);
            memCnt++;
         end else begin
            mem_ready = 1'b0;
         end
         #1;
         if (mem_read) rdCnt++;
         if (mem_write) wrCnt++;
         if (reg_write) begin
            rwCnt++;
            obsM2r = mem_to_reg;
         end
         if (pc_write) begin
            pwCnt++;
            obsPcSrc = pc_src;
         end
         if (int'(mem_read) + int'(mem_write) + int'(reg_write) > 1) ovl++;
      end
      mem_ready = 1'b0;
      retModel = (retModel + 1) & 16'hFFFF;
      checkOutput($sformatf("v%0d cycles", idx), cyc, v.expCycles);
      checkOutput($sformatf("v%0d alu_src_exec", idx), obsAluSrc, v.expAluSrc);
      checkOutput($sformatf("v%0d alu_op_exec", idx), obsAluOp, v.expAluOp);
      checkOutput($sformatf("v%0d reg2loc", idx), obsReg2loc, v.expReg2loc);
      checkOutput($sformatf("v%0d pc_src", idx), obsPcSrc, v.expPcSrc);
      checkOutput($sformatf("v%0d pc_write_cnt", idx), pwCnt, 1);
      checkOutput($sformatf("v%0d mem_read_cnt", idx), rdCnt, v.expRd);
      checkOutput($sformatf("v%0d mem_write_cnt", idx), wrCnt, v.expWr);
      checkOutput($sformatf("v%0d reg_write_cnt", idx), rwCnt, v.expRw);
      checkOutput($sformatf("v%0d mem_to_reg", idx), obsM2r, v.expM2r);
      checkOutput($sformatf("v%0d enable_overlap", idx), ovl, 0);
      checkOutput($sformatf("v%0d retired", idx), retired, retModel);
   endtask

   initial begin
      int cnt, tick, last, badGap, badSrc, trapCnt, retBefore;

      vecs[0]  = '{11'b10001011000, 1'b1, 0, 4, 1'b0, 2'b10, 1'b0, 1'b0, 0, 0, 1, 1'b0};
      vecs[1]  = '{11'b11001011000, 1'b0, 0, 4, 1'b0, 2'b10, 1'b0, 1'b0, 0, 0, 1, 1'b0};
      vecs[2]  = '{11'b10001010000, 1'b0, 0, 4, 1'b0, 2'b10, 1'b0, 1'b0, 0, 0, 1, 1'b0};
      vecs[3]  = '{11'b10101010000, 1'b0, 0, 4, 1'b0, 2'b10, 1'b0, 1'b0, 0, 0, 1, 1'b0};
      vecs[4]  = '{11'b11111000010, 1'b0, 2, 7, 1'b1, 2'b00, 1'b0, 1'b0, 3, 0, 1, 1'b1};
      vecs[5]  = '{11'b11111000000, 1'b0, 0, 4, 1'b1, 2'b00, 1'b1, 1'b0, 0, 1, 0, 1'b0};
      vecs[6]  = '{11'b10110100101, 1'b1, 0, 3, 1'b0, 2'b01, 1'b1, 1'b1, 0, 0, 0, 1'b0};
      vecs[7]  = '{11'b10110100011, 1'b0, 0, 3, 1'b0, 2'b01, 1'b1, 1'b0, 0, 0, 0, 1'b0};
      vecs[8]  = '{11'b00010111111, 1'b0, 0, 3, 1'b0, 2'b00, 1'b0, 1'b1, 0, 0, 0, 1'b0};
      vecs[9]  = '{11'b11111000010, 1'b1, 0, 5, 1'b1, 2'b00, 1'b0, 1'b0, 1, 0, 1, 1'b1};
      vecs[10] = '{11'b11111000000, 1'b1, 3, 7, 1'b1, 2'b00, 1'b1, 1'b0, 0, 4, 0, 1'b0};

      rst_n = 1'b0; instr_valid = 1'b0; opcode = '0; alu_zero = 1'b0;
      mem_ready = 1'b0; trap_clr = 1'b0;
      #1;
      checkOutput("reset instr_ready", instr_ready, 1);
      checkOutput("reset pc_write", pc_write, 0);
      checkOutput("reset illegal", illegal, 0);
      checkOutput("reset retired", retired, 0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);

      for (int i = 0; i < 11; i++)
         applyStimulus(i, vecs[i]);

      // Reset asserted during WB of an ADD.
      opcode = 11'b10001011000; instr_valid = 1'b1;
      @(posedge clk);
      #1 instr_valid = 1'b0;
      repeat (3) @(negedge clk);
      checkOutput("wb reg_write", reg_write, 1);
      checkOutput("wb pc_write", pc_write, 1);
      rst_n = 1'b0;
      #1;
      checkOutput("async reg_write", reg_write, 0);
      checkOutput("async pc_write", pc_write, 0);
      checkOutput("async instr_ready", instr_ready, 1);
      checkOutput("async retired", retired, 0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      retModel = 0;
      checkOutput("post-reset instr_ready", instr_ready, 1);
      checkOutput("post-reset retired", retired, 0);
      checkOutput("post-reset retired4", r4Retired, 0);

      // Sixteen back-to-back B instructions with instr_valid held high.
      opcode = 11'b00010100000; instr_valid = 1'b1;
      cnt = 0; tick = 0; last = 0; badGap = 0; badSrc = 0;
      if (instr_ready) cnt = 1;
      while (cnt < 16 && tick < 200) begin
         @(negedge clk);
         tick++;
         if (pc_write && !pc_src) badSrc++;
         if (instr_ready) begin
            if (tick - last != 3) badGap++;
            last = tick;
            cnt++;
         end
      end
      @(posedge clk);
      #1 instr_valid = 1'b0;
      repeat (3) @(negedge clk);
      checkOutput("b accepts", cnt, 16);
      checkOutput("b spacing errors", badGap, 0);
      checkOutput("b pc_src errors", badSrc, 0);
      checkOutput("b ready after last", instr_ready, 1);
      checkOutput("b retired", retired, 16);
      checkOutput("b retired4 wrap", r4Retired, 0);
      retBefore = retired;

      // Illegal opcode parks in TRAP until trap_clr.
      opcode = 11'h7FF; instr_valid = 1'b1;
      @(posedge clk);
      #1 instr_valid = 1'b0;
      @(negedge clk);
      trapCnt = 0;
      for (int k = 0; k < 10; k++) begin
         @(negedge clk);
         if (illegal && !instr_ready && !pc_write && !reg_write && !mem_read && !mem_write)
            trapCnt++;
      end
      checkOutput("trap held cycles", trapCnt, 10);
      trap_clr = 1'b1;
      @(negedge clk);
      trap_clr = 1'b0;
      checkOutput("trap clr instr_ready", instr_ready, 1);
      checkOutput("trap clr illegal", illegal, 0);
      checkOutput("trap retired", retired, retBefore);

      $display("[TB] %0d/%0d checks passed", passCnt, checkCnt);
      $finish;
   end

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: got timeout expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

endmodule
